// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
//   timer_state_e  : controller state (Idle, Running, Paused, Expired)
//   DEFAULT_CLK_HZ : production clock rate
//   SIM_CLK_HZ     : short "second" used for simulation
package timer_pkg;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Running = 2'd1,
    Paused  = 2'd2,
    Expired = 2'd3
  } timer_state_e;

  localparam int unsigned DEFAULT_CLK_HZ = 100_000_000;
  localparam int unsigned SIM_CLK_HZ     = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-cycle tick per second.
//   clock  : system clock
//   reset  : asynchronous, active-low reset
//   enable : advance the prescaler this cycle
//   clear  : force the prescaler to 0 (wins over enable)
//   tick   : high in the last cycle of each second while enabled
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = enable && (presc_q == PrescLast);

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable seconds countdown with pause, abort, optional auto-reload and a
// 0.5 Hz blink strobe.
//   clock          : system clock
//   reset          : asynchronous, active-low reset
//   start_timer    : load value and start counting
//   value          : seconds to count
//   pause          : level, freezes the countdown while high
//   abort          : return to Idle and clear the count
//   expired        : state is Expired (level, or one-cycle pulse with auto-reload)
//   running        : state is Running
//   half_hz_enable : one-cycle strobe every second second of prescaler time
//   value_display  : remaining whole seconds
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEFAULT_CLK_HZ,
  parameter int unsigned SEC_W       = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_timer,
  input  logic [SEC_W-1:0] value,
  input  logic             pause,
  input  logic             abort,
  output logic             expired,
  output logic             running,
  output logic             half_hz_enable,
  output logic [SEC_W-1:0] value_display
);

  timer_state_e     state_q, state_d;
  logic [SEC_W-1:0] count_q, count_d;
  logic [SEC_W-1:0] reload_q, reload_d;
  logic             blink_q, blink_d;
  logic             sec_tick, presc_en, presc_clr, reload_now;

  // A zero reload value stays in Expired rather than oscillating.
  assign reload_now = (state_q == Expired) && AUTO_RELOAD && (reload_q != '0);

  assign presc_clr = abort || start_timer || (state_q == Idle) || reload_now;

  // Counting is tied to the pause level rather than the state, so a pause of
  // P cycles delays expiry by exactly P cycles.
  assign presc_en = !abort && !start_timer &&
                    ((((state_q == Running) || (state_q == Paused)) && !pause) ||
                     ((state_q == Expired) && !reload_now));

  tick_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (presc_en),
    .clear  (presc_clr),
    .tick   (sec_tick)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    blink_d  = blink_q;
    if (abort) begin
      state_d = Idle;
      count_d = '0;
      blink_d = 1'b0;
    end else if (start_timer) begin
      count_d  = value;
      reload_d = value;
      if (value == '0) begin
        state_d = Expired;
      end else if (pause) begin
        state_d = Paused;
      end else begin
        state_d = Running;
      end
    end else begin
      if (sec_tick) begin
        blink_d = ~blink_q;
      end
      unique case (state_q)
        Idle: begin
          state_d = Idle;
        end
        Running, Paused: begin
          if (pause) begin
            state_d = Paused;
          end else begin
            state_d = Running;
            if (sec_tick) begin
              // <= 1 also guards against decrementing past zero.
              if (count_q <= SEC_W'(1)) begin
                count_d = '0;
                state_d = Expired;
              end else begin
                count_d = count_q - 1'b1;
              end
            end
          end
        end
        Expired: begin
          if (reload_now) begin
            state_d = Running;
            count_d = reload_q;
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= Idle;
      count_q  <= '0;
      reload_q <= '0;
      blink_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      blink_q  <= blink_d;
    end
  end

  assign running        = (state_q == Running);
  assign expired        = (state_q == Expired);
  assign half_hz_enable = sec_tick & blink_q;
  assign value_display  = count_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one instance without and one with auto-reload,
// driven by the same stimulus and checked every cycle against a model that
// tracks elapsed unpaused cycles and derives seconds and ticks arithmetically.
module tb_countdown_timer;

  localparam int C = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_timer = 1'b0;
  logic [3:0] value = '0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;

  logic [1:0] expired_w, running_w, hh_w;
  logic [3:0] disp_w [2];

  int n_compared = 0;
  int n_mismatched = 0;

  // Model: mode 0 idle, 1 counting, 2 expired.
  int m_mode [2];
  int m_n    [2];
  int m_rel  [2];
  int m_en   [2];   // prescaler-enabled cycles since last clear
  bit m_run  [2];
  bit m_ph   [2];   // odd number of ticks since reset/abort
  bit hh_last;

  always #5 clock = ~clock;

  countdown_timer #(.CLK_HZ(C), .SEC_W(4), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .value          (value),
    .pause          (pause),
    .abort          (abort),
    .expired        (expired_w[0]),
    .running        (running_w[0]),
    .half_hz_enable (hh_w[0]),
    .value_display  (disp_w[0])
  );

  countdown_timer #(.CLK_HZ(C), .SEC_W(4), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clock          (clock),
    .reset          (reset),
    .start_timer    (start_timer),
    .value          (value),
    .pause          (pause),
    .abort          (abort),
    .expired        (expired_w[1]),
    .running        (running_w[1]),
    .half_hz_enable (hh_w[1]),
    .value_display  (disp_w[1])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_compared++;
    if (got != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_n[d] = 0; m_rel[d] = 0; m_en[d] = 0; m_run[d] = 0; m_ph[d] = 0;
    end
  endtask

  function automatic bit model_tick(input int d, input bit st, input bit ab, input bit pa);
    bit en;
    en = 1'b0;
    if (!ab && !st) begin
      if (m_mode[d] == 1 && !pa) en = 1'b1;
      if (m_mode[d] == 2 && !(d == 1 && m_rel[d] != 0)) en = 1'b1;
    end
    return en && ((m_en[d] % C) == C - 1);
  endfunction

  task automatic model_step(input int d, input bit st, input int val, input bit pa,
                            input bit ab, input bit tk);
    if (ab) begin
      m_mode[d] = 0; m_n[d] = 0; m_en[d] = 0; m_ph[d] = 0;
    end else if (st) begin
      m_n[d] = val; m_rel[d] = val; m_en[d] = 0;
      if (val == 0) m_mode[d] = 2;
      else begin
        m_mode[d] = 1; m_run[d] = !pa;
      end
    end else if (m_mode[d] == 1) begin
      m_run[d] = !pa;
      if (!pa) begin
        if (tk) m_ph[d] = !m_ph[d];
        m_en[d]++;
        if (m_en[d] == m_n[d] * C) m_mode[d] = 2;
      end
    end else if (m_mode[d] == 2) begin
      if (d == 1 && m_rel[d] != 0) begin
        m_mode[d] = 1; m_n[d] = m_rel[d]; m_en[d] = 0; m_run[d] = 1;
      end else begin
        if (tk) m_ph[d] = !m_ph[d];
        m_en[d]++;
      end
    end
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model past posedge.
  task automatic cycle(input bit st, input int val, input bit pa, input bit ab);
    bit tk [2];
    @(negedge clock);
    start_timer = st; value = 4'(val); pause = pa; abort = ab;
    #1;
    for (int d = 0; d < 2; d++) begin
      tk[d] = model_tick(d, st, ab, pa);
      check($sformatf("d%0d_running", d), int'(running_w[d]), int'(m_mode[d] == 1 && m_run[d]));
      check($sformatf("d%0d_expired", d), int'(expired_w[d]), int'(m_mode[d] == 2));
      check($sformatf("d%0d_display", d), int'(disp_w[d]),
            (m_mode[d] == 1) ? (m_n[d] - m_en[d] / C) : 0);
      check($sformatf("d%0d_half_hz", d), int'(hh_w[d]), int'(tk[d] && m_ph[d]));
    end
    hh_last = hh_w[0];
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) model_step(d, st, val, pa, ab, tk[d]);
  endtask

  task automatic mid_reset();
    #2;
    start_timer = 0; pause = 0; abort = 0;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_outputs", d),
            int'({expired_w[d], running_w[d], hh_w[d], disp_w[d]}), 0);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int e, e1, last_pulse, n_pulse;
    bit pz;
    model_reset();
    #12;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("init%0d_outputs", d),
            int'({expired_w[d], running_w[d], hh_w[d], disp_w[d]}), 0);
    end
    @(negedge clock);
    reset = 1'b1;

    // Basic countdown: expiry 12 edges after the start edge, held.
    cycle(1, 3, 0, 0);
    e = 0;
    while (!expired_w[0] && e < 40) begin cycle(0, 0, 0, 0); e++; end
    check("basic_expiry_edge", e, 12);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
    check("basic_held", int'(expired_w[0]), 1);

    // Pause for 6 cycles from edge 5: expiry at edge 18.
    cycle(1, 3, 0, 0);
    for (int i = 1; i <= 5; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
    check("pause_display", int'(disp_w[0]), 2);
    e = 11;
    while (!expired_w[0] && e < 60) begin cycle(0, 0, 0, 0); e++; end
    check("pause_expiry_edge", e, 18);

    // Zero load.
    cycle(1, 0, 0, 0);
    check("zero_expired", int'(expired_w[0]), 1);
    check("zero_running", int'(running_w[0]), 0);
    cycle(0, 0, 0, 0);

    // Auto-reload period of 9 on the second instance.
    cycle(1, 2, 0, 0);
    e = 0;
    while (!expired_w[1] && e < 40) begin cycle(0, 0, 0, 0); e++; end
    check("reload_first_edge", e, 8);
    cycle(0, 0, 0, 0);
    check("reload_pulse_width", int'(expired_w[1]), 0);
    check("reload_display", int'(disp_w[1]), 2);
    e1 = e + 1;
    while (!expired_w[1] && e1 < 60) begin cycle(0, 0, 0, 0); e1++; end
    check("reload_period", e1 - e, 9);

    // Abort wins over start.
    cycle(1, 5, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
    cycle(1, 7, 0, 1);
    check("abort_display", int'(disp_w[0]), 0);
    check("abort_expired", int'(expired_w[0] | expired_w[1]), 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);

    // Blink strobe while expired without reload: one pulse per 8 cycles.
    cycle(1, 1, 0, 0);
    last_pulse = -1; n_pulse = 0;
    for (int i = 0; i < 44; i++) begin
      cycle(0, 0, 0, 0);
      if (hh_last) begin
        if (last_pulse >= 0) check("blink_interval", i - last_pulse, 8);
        last_pulse = i;
        n_pulse++;
      end
    end
    check("blink_seen", int'(n_pulse >= 3), 1);

    // Asynchronous reset mid-run.
    cycle(1, 9, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0);
    mid_reset();

    // Randomised traffic.
    pz = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      bit st, ab;
      int val;
      st = ($urandom_range(0, 29) == 0);
      ab = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 11) == 0) pz = !pz;
      val = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      cycle(st, val, pz, ab);
      if (i == 1300) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
